// File: rtl/rtc_bridge_pkg.sv
// Shared definitions for the RTC bus bridge: port map, STATUS layout, FSM states
// and the per-state bus pin decode.
package rtc_bridge_pkg;

    localparam logic [7:0] PORT_ADDR   = 8'h01;
    localparam logic [7:0] PORT_WDATA  = 8'h02;
    localparam logic [7:0] PORT_CMD    = 8'h03;
    localparam logic [7:0] PORT_STATUS = 8'h04;
    localparam logic [7:0] PORT_RDATA  = 8'h05;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_IRQ     = 1;
    localparam int STATUS_OVERRUN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad_n;
        logic       ad_oe;
        logic [7:0] ad_o;
    } bus_pins_t;

    localparam bus_pins_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_n: 1'b1,
                                       ad_oe: 1'b0, ad_o: 8'h00};

    function automatic state_e next_phase(input state_e st);
        case (st)
            ST_A_SETUP:  return ST_A_STROBE;
            ST_A_STROBE: return ST_A_HOLD;
            ST_A_HOLD:   return ST_D_SETUP;
            ST_D_SETUP:  return ST_D_STROBE;
            ST_D_STROBE: return ST_D_HOLD;
            ST_D_HOLD:   return ST_DONE;
            default:     return ST_IDLE;
        endcase
    endfunction

    // Pin values a state presents for its whole duration; read data phases float the bus.
    function automatic bus_pins_t bus_pins(input state_e st, input logic is_wr,
                                           input logic [7:0] addr, input logic [7:0] wdata);
        bus_pins_t p;
        p = BUS_IDLE;
        case (st)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                p.cs_n  = 1'b0;
                p.ad_n  = 1'b0;
                p.ad_oe = 1'b1;
                p.ad_o  = addr;
                p.wr_n  = (st != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                p.cs_n = 1'b0;
                p.ad_n = 1'b1;
                if (is_wr) begin
                    p.ad_oe = 1'b1;
                    p.ad_o  = wdata;
                    p.wr_n  = (st != ST_D_STROBE);
                end else begin
                    p.rd_n = (st != ST_D_STROBE);
                end
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: reloads T_PHASE-1 on each state entry and flags the last cycle of a phase.
module rtc_phase_timer #(
    parameter int T_PHASE = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_phase_done
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= 8'(T_PHASE - 1);
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_phase_done = (r_count == 8'd0);

endmodule

// File: rtl/rtc_bus_bridge.sv
// PicoBlaze port-bus peripheral running timed multiplexed A/D transactions to an RTC chip.
// Define RTC_BRIDGE_IRQ_EN to drive interrupt; otherwise completion is polled through STATUS.
module rtc_bus_bridge
    import rtc_bridge_pkg::*;
#(
    parameter int T_PHASE = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_ad_n,
    output logic [7:0] rtc_ad_o,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_i
);

    state_e     r_state;
    bus_pins_t  r_pins;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [7:0] r_tx_addr;
    logic [7:0] r_tx_wdata;
    logic [7:0] r_in_port;
    logic       r_tx_wr;
    logic       r_irq;
    logic       r_overrun;

    logic       w_busy;
    logic       w_cmd;
    logic       w_start;
    logic       w_status_rd;
    logic       w_phase_state;
    logic       w_phase_done;
    logic       w_timer_load;
    logic       w_irq_clr;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_cmd         = write_strobe && (port_id == PORT_CMD);
    assign w_start       = w_cmd && !w_busy;
    assign w_status_rd   = read_strobe && (port_id == PORT_STATUS);
    assign w_phase_state = w_busy && (r_state != ST_DONE);
    assign w_timer_load  = w_start || (w_phase_state && w_phase_done);

    rtc_phase_timer #(.T_PHASE(T_PHASE)) u_phase_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .o_phase_done (w_phase_done)
    );

    // Pins are registered alongside the state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pins     <= BUS_IDLE;
            r_tx_addr  <= 8'h00;
            r_tx_wdata <= 8'h00;
            r_tx_wr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_A_SETUP;
                        r_tx_addr  <= r_addr;
                        r_tx_wdata <= r_wdata;
                        r_tx_wr    <= out_port[0];
                        r_pins     <= bus_pins(ST_A_SETUP, out_port[0], r_addr, r_wdata);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_pins  <= BUS_IDLE;
                end
                default: begin
                    if (w_phase_done) begin
                        r_state <= next_phase(r_state);
                        r_pins  <= bus_pins(next_phase(r_state), r_tx_wr, r_tx_addr, r_tx_wdata);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
        end else if (write_strobe) begin
            if (port_id == PORT_ADDR) begin
                r_addr <= out_port;
            end
            if (port_id == PORT_WDATA) begin
                r_wdata <= out_port;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= 8'h00;
        end else if ((r_state == ST_D_STROBE) && w_phase_done && !r_tx_wr) begin
            r_rdata <= rtc_ad_i;
        end
    end

    // Setting a flag takes priority over clearing it in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == ST_DONE) begin
                r_irq <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq <= 1'b0;
            end
            if (w_cmd && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_status_rd) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_port <= 8'h00;
        end else begin
            case (port_id)
                PORT_STATUS: begin
                    r_in_port                 <= 8'h00;
                    r_in_port[STATUS_BUSY]    <= w_busy;
                    r_in_port[STATUS_IRQ]     <= r_irq;
                    r_in_port[STATUS_OVERRUN] <= r_overrun;
                end
                PORT_RDATA: r_in_port <= r_rdata;
                default:    r_in_port <= 8'h00;
            endcase
        end
    end

`ifdef RTC_BRIDGE_IRQ_EN
    assign w_irq_clr = interrupt_ack;
    assign interrupt = r_irq;
`else
    // Polled mode: reading STATUS retires the completion flag and the acknowledge has no effect.
    assign w_irq_clr = w_status_rd;
    assign interrupt = 1'b0 & interrupt_ack;
`endif

    assign in_port   = r_in_port;
    assign rtc_cs_n  = r_pins.cs_n;
    assign rtc_rd_n  = r_pins.rd_n;
    assign rtc_wr_n  = r_pins.wr_n;
    assign rtc_ad_n  = r_pins.ad_n;
    assign rtc_ad_oe = r_pins.ad_oe;
    assign rtc_ad_o  = r_pins.ad_o;

endmodule
